// File: rtl/control_unit_pkg.sv
// Shared constants for the control unit: opcode and funct encodings,
// ALU_Control codes, and the packed bundle of datapath controls.
package control_unit_pkg;

    // Opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000010;

    // R-type function fields
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU_Control encodings; ALU_NONE doubles as "no operation"
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    // One decoded instruction's worth of datapath controls
    typedef struct packed {
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_control;
    } ctrl_t;

endpackage

// File: rtl/control_unit_alu_dec.sv
// R-type funct to ALU_Control mapping. Purely combinational; known flags
// whether funct is one of the supported operations.
module control_unit_alu_dec
    import control_unit_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic       known
);

    // Table lookup; anything unlisted maps to ALU_NONE and is flagged unknown
    always_comb begin
        alu_code = ALU_NONE;
        known    = 1'b1;
        case (funct)
            FN_ADD:  alu_code = ALU_ADD;
            FN_SUB:  alu_code = ALU_SUB;
            FN_AND:  alu_code = ALU_AND;
            FN_OR:   alu_code = ALU_OR;
            FN_XOR:  alu_code = ALU_XOR;
            FN_NOR:  alu_code = ALU_NOR;
            FN_SLT:  alu_code = ALU_SLT;
            default: begin
                alu_code = ALU_NONE;
                known    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Single-cycle-latency instruction control decoder.
// Handshake: in_valid qualifies opcode/funct in the cycle it is high; there
// is no backpressure. out_valid is in_valid delayed by one clock and marks
// the cycle in which the registered controls belong to that instruction.
// Optional feature: define CONTROL_UNIT_ILLEGAL_EN to add the registered
// "illegal" output (unknown opcode or unknown R-type funct).
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       out_valid,
    output logic       RegDst,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [3:0] ALU_Control
`ifdef CONTROL_UNIT_ILLEGAL_EN
    ,
    output logic       illegal
`endif
);

    logic       is_rtype;
    logic [5:0] funct_gated;
    logic [3:0] alu_code;
    logic       funct_known;
    ctrl_t      dec;
    logic       dec_illegal;

    assign is_rtype = (opcode == OP_RTYPE);

    // funct is forced to zero for non-R-type opcodes so an undriven funct
    // field can never reach the outputs through the ALU decoder.
    assign funct_gated = is_rtype ? funct : 6'b000000;

    control_unit_alu_dec u_alu_dec (
        .funct    (funct_gated),
        .alu_code (alu_code),
        .known    (funct_known)
    );

    // Combinational decode of the current opcode into datapath controls
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        if (in_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    dec.reg_dst     = 1'b1;
                    dec.reg_write   = funct_known;
                    dec.alu_control = alu_code;
                    dec_illegal     = ~funct_known;
                end
                OP_LW: begin
                    dec.alu_src     = 1'b1;
                    dec.mem_read    = 1'b1;
                    dec.mem_to_reg  = 1'b1;
                    dec.reg_write   = 1'b1;
                    dec.alu_control = ALU_ADD;
                end
                OP_SW: begin
                    dec.alu_src     = 1'b1;
                    dec.mem_write   = 1'b1;
                    dec.alu_control = ALU_ADD;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    // Output registers: clear on reset, otherwise capture the decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            RegDst      <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            MemToReg    <= 1'b0;
            ALUSrc      <= 1'b0;
            RegWrite    <= 1'b0;
            ALU_Control <= ALU_NONE;
        end else begin
            out_valid   <= in_valid;
            RegDst      <= dec.reg_dst;
            MemRead     <= dec.mem_read;
            MemWrite    <= dec.mem_write;
            MemToReg    <= dec.mem_to_reg;
            ALUSrc      <= dec.alu_src;
            RegWrite    <= dec.reg_write;
            ALU_Control <= dec.alu_control;
        end
    end

`ifdef CONTROL_UNIT_ILLEGAL_EN
    // Registered illegal-instruction flag, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else begin
            illegal <= dec_illegal;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios followed by random traffic,
// each cycle compared against a table-driven reference model.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       out_valid;
    logic       RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
    logic [3:0] ALU_Control;
    logic       ill_obs;

    int checks = 0;
    int errors = 0;

`ifdef CONTROL_UNIT_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
    logic illegal;
    assign ill_obs = illegal;
`else
    localparam bit ILL_EN = 1'b0;
    assign ill_obs = 1'b0;
`endif

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .opcode      (opcode),
        .funct       (funct),
        .out_valid   (out_valid),
        .RegDst      (RegDst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .ALU_Control (ALU_Control)
`ifdef CONTROL_UNIT_ILLEGAL_EN
        ,
        .illegal     (illegal)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R-type operation table: funct value -> ALU code
    int alu_map [int];
    int known_functs [$];

    // Expected {out_valid, RegDst, MemRead, MemWrite, MemToReg, ALUSrc,
    // RegWrite, ALU_Control[3:0], illegal} after one edge with these inputs.
    function automatic logic [11:0] model(input logic r, input logic v,
                                          input logic [5:0] op, input logic [5:0] fn);
        int rd, mr, mw, m2r, as, rw, alu, ill;
        rd = 0; mr = 0; mw = 0; m2r = 0; as = 0; rw = 0; alu = 0; ill = 0;
        if (!r) return 12'h000;
        if (!v) return 12'h000;
        if (op == 6'd1) begin
            rd = 1;
            if (alu_map.exists(int'(fn))) begin
                alu = alu_map[int'(fn)];
                rw  = 1;
            end else begin
                ill = 1;
            end
        end else if (op == 6'd4) begin
            as = 1; mr = 1; m2r = 1; rw = 1; alu = 5;
        end else if (op == 6'd2) begin
            as = 1; mw = 1; alu = 5;
        end else begin
            ill = 1;
        end
        return {1'b1, rd[0], mr[0], mw[0], m2r[0], as[0], rw[0], alu[3:0],
                ILL_EN ? ill[0] : 1'b0};
    endfunction

    // Drive one cycle of inputs at negedge, check registered outputs after posedge
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [5:0] op, input logic [5:0] fn);
        logic [11:0] exp_v, obs_v;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        opcode   = op;
        funct    = fn;
        exp_v    = model(r, v, op, fn);
        @(posedge clk);
        #1;
        obs_v = {out_valid, RegDst, MemRead, MemWrite, MemToReg, ALUSrc,
                 RegWrite, ALU_Control, ill_obs};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs_v, exp_v);
        end
        checks++;
        assert (!(MemRead === 1'b1 && MemWrite === 1'b1)) else begin
            errors++;
            $error("FAIL %s mem_excl observed rd=%b wr=%b expected not both 1",
                   tag, MemRead, MemWrite);
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        logic       v, r;
        int         sel;

        alu_map[32] = 5;  // ADD
        alu_map[34] = 6;  // SUB
        alu_map[36] = 1;  // AND
        alu_map[37] = 2;  // OR
        alu_map[38] = 3;  // XOR
        alu_map[39] = 4;  // NOR
        alu_map[42] = 7;  // SLT
        foreach (alu_map[k]) known_functs.push_back(k);

        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct = '0;

        // reset and idle
        step("reset0", 1'b0, 1'b1, 6'b000100, 6'b000000);
        step("reset1", 1'b0, 1'b1, 6'b000001, 6'b100000);
        step("idle",   1'b1, 1'b0, 6'b000001, 6'b100000);

        // directed decodes
        step("r_add",    1'b1, 1'b1, 6'b000001, 6'b100000);
        step("r_bad",    1'b1, 1'b1, 6'b000001, 6'b000000);
        step("lw_fx",    1'b1, 1'b1, 6'b000100, 6'bxxxxxx);
        step("sw",       1'b1, 1'b1, 6'b000010, 6'b101010);
        step("bad_op",   1'b1, 1'b1, 6'b111111, 6'b100000);
        step("r_slt",    1'b1, 1'b1, 6'b000001, 6'b101010);
        step("r_nor",    1'b1, 1'b1, 6'b000001, 6'b100111);
        step("inv_lw",   1'b1, 1'b0, 6'b000100, 6'b000000);
        step("lw",       1'b1, 1'b1, 6'b000100, 6'b000000);
        step("rst_mid",  1'b0, 1'b1, 6'b000100, 6'b000000);
        step("post_rst", 1'b1, 1'b1, 6'b000100, 6'b000000);
        step("zero_op",  1'b1, 1'b1, 6'b000000, 6'b100000);

        // every supported R-type funct
        foreach (known_functs[i])
            step("r_table", 1'b1, 1'b1, 6'b000001, 6'(known_functs[i]));

        // random traffic
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = 6'b000001;
                1: op = 6'b000100;
                2: op = 6'b000010;
                default: op = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 0)
                fn = 6'(known_functs[$urandom_range(0, known_functs.size() - 1)]);
            else
                fn = 6'($urandom_range(0, 63));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 19) != 0);
            step("random", r, v, op, fn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use a single clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  opcode/funct valid this cycle.
REQ-006 opcode  input  6  instruction opcode.
REQ-007 funct  input  6  R-type function field; ignored for every non-R-type opcode.
REQ-008 out_valid  output  1  registered decode valid.
REQ-009 RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite  output  1 each  registered datapath controls.
REQ-010 ALU_Control  output  4  registered ALU operation code.

Function
REQ-011 Decode SHALL be combinational and captured in output registers, giving exactly 1-cycle latency (inputs at edge N visible after edge N).
REQ-012 out_valid SHALL equal in_valid registered.
REQ-013 in_valid=0 SHALL register all controls and ALU_Control as 0.
REQ-014 opcode 000001 (R-type) SHALL decode to RegDst=1, ALUSrc=0, MemRead=0, MemWrite=0, MemToReg=0, RegWrite=1.
REQ-015 R-type ALU_Control by funct SHALL be: 100000 ADD=0101, 100010 SUB=0110, 100100 AND=0001, 100101 OR=0010, 100110 XOR=0011, 100111 NOR=0100, 101010 SLT=0111.
REQ-016 An R-type with any other funct SHALL give ALU_Control=0000 and RegWrite=0, with RegDst=1 still set.
REQ-017 opcode 000100 (LW) SHALL decode to RegDst=0, ALUSrc=1, MemRead=1, MemWrite=0, MemToReg=1, RegWrite=1, ALU_Control=0101.
REQ-018 opcode 000010 (SW) SHALL decode to RegDst=0, ALUSrc=1, MemRead=0, MemWrite=1, MemToReg=0, RegWrite=0, ALU_Control=0101.
REQ-019 Any other opcode SHALL decode to all controls 0 and ALU_Control=0000.
REQ-020 X/Z on funct with a non-R-type opcode SHALL NOT propagate to any output.
REQ-021 MemRead and MemWrite SHALL never both be 1.

Reset
REQ-022 When rst_n=0 at a rising edge, every output, out_valid included, SHALL be 0 after that edge.
REQ-023 Reset SHALL override in_valid, and the first decode SHALL appear one cycle after the first edge with rst_n=1 and in_valid=1.

Configuration
REQ-024 With macro CONTROL_UNIT_ILLEGAL_EN defined, a 1-bit registered output illegal SHALL be present.
REQ-025 illegal SHALL be 1 for a valid unknown opcode or a valid R-type with an unknown funct, and 0 otherwise and during reset.
REQ-026 With CONTROL_UNIT_ILLEGAL_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package control_unit_pkg SHALL hold the opcode constants (R-type, LW, SW), the funct constants, and the 4-bit ALU_Control encodings.
REQ-028 The funct-to-ALU_Control mapping SHALL be a combinational sub-module control_unit_alu_dec, instantiated once.

Verification
REQ-029 rst_n=0 for 2 cycles, then rst_n=1 with in_valid=0 -> all outputs 0 and out_valid=0.
REQ-030 in_valid=1, opcode=000001, funct=100000 -> next cycle RegDst=1, RegWrite=1, ALUSrc=0, ALU_Control=0101, out_valid=1.
REQ-031 opcode=000001, funct=000000 -> ALU_Control=0000 and RegWrite=0, plus illegal=1 when CONTROL_UNIT_ILLEGAL_EN is defined.
REQ-032 opcode=000100, funct=X -> MemRead=1, MemToReg=1, ALUSrc=1, RegWrite=1, ALU_Control=0101, with no X on any output.
REQ-033 opcode=000010, then opcode=111111 -> first MemWrite=1, ALUSrc=1, RegWrite=0, ALU_Control=0101, then all controls 0 and ALU_Control=0000.
REQ-034 rst_n=0 asserted mid-stream during an LW decode -> all outputs 0 after the next edge.
